// File: rtl/decode1_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : decode1_lanes
//  Description : Multi-lane first-stage RV32 decoder. Classifies each lane of
//                an incoming bundle into unit / operand / immediate enables
//                and registers the result behind a 2-entry skid buffer with
//                valid/ready handshakes on both sides. Counts delivered lanes.
//                Optional M-extension decode is enabled by DECODE1_MULDIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode1_lanes #(
    parameter int LANES = 2,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_vld,
    input  logic [LANES*32-1:0]   in_ins,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_vld,
    output logic [LANES*32-1:0]   out_ins,
    output logic [LANES-1:0]      out_rs1_en,
    output logic [LANES-1:0]      out_rs2_en,
    output logic [LANES-1:0]      out_wb_en,
    output logic [LANES-1:0]      out_int_en,
    output logic [LANES-1:0]      out_muldiv_en,
    output logic [LANES-1:0]      out_mem_en,
    output logic [LANES-1:0]      out_bj_en,
    output logic [LANES-1:0]      out_s1_sign,
    output logic [LANES-1:0]      out_s2_sign,
    output logic [LANES-1:0]      out_iimm_u_en,
    output logic [LANES-1:0]      out_iimm_s_en,
    output logic [LANES-1:0]      out_uimm_en,
    output logic [LANES-1:0]      out_ujimm_en,
    output logic [LANES-1:0]      out_sbimm_en,
    output logic [LANES-1:0]      out_shamt_en,
    output logic [LANES-1:0]      out_illegal,
    output logic                  out_mem_any,
    output logic [CNT_W-1:0]      decoded_cnt
);

    // Bit positions of the per-lane decode fields inside one field word
    localparam int c_NF       = 16;
    localparam int c_F_RS1    = 0;
    localparam int c_F_RS2    = 1;
    localparam int c_F_WB     = 2;
    localparam int c_F_INT    = 3;
    localparam int c_F_MULDIV = 4;
    localparam int c_F_MEM    = 5;
    localparam int c_F_BJ     = 6;
    localparam int c_F_S1     = 7;
    localparam int c_F_S2     = 8;
    localparam int c_F_IIMMU  = 9;
    localparam int c_F_IIMMS  = 10;
    localparam int c_F_UIMM   = 11;
    localparam int c_F_UJIMM  = 12;
    localparam int c_F_SBIMM  = 13;
    localparam int c_F_SHAMT  = 14;
    localparam int c_F_ILL    = 15;

    // Skid-buffer occupancy states
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    logic [LANES-1:0][c_NF-1:0] w_decFld;
    logic [LANES*32-1:0]        w_decIns;

    logic [1:0]                 r_state;
    logic                       r_outValid;
    logic                       r_inReady;
    logic [LANES-1:0]           r_outLaneVld;
    logic [LANES*32-1:0]        r_outIns;
    logic [LANES-1:0][c_NF-1:0] r_outFld;
    logic [LANES-1:0]           r_skdLaneVld;
    logic [LANES*32-1:0]        r_skdIns;
    logic [LANES-1:0][c_NF-1:0] r_skdFld;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_pop;

    logic w_accept;
    logic w_drain;

    // A bundle presented during flush is dropped, never captured
    assign w_accept = in_valid & r_inReady & ~flush;
    assign w_drain  = r_outValid & out_ready;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_dec
        logic [31:0]     w_ins;
        logic [6:0]      w_op;
        logic [2:0]      w_f3;
        logic            w_mdEnc;
        logic            w_muldiv;
        logic            w_mdIll;
        logic            w_mem;
        logic            w_bj;
        logic            w_int;
        logic            w_wb;
        logic            w_uns;
        logic            w_s1;
        logic            w_s2;
        logic            w_iimmU;
        logic            w_iimmS;
        logic [c_NF-1:0] w_fld;
        logic [31:0]     w_insOut;

        assign w_ins   = in_ins[32*gi +: 32];
        assign w_op    = w_ins[6:0];
        assign w_f3    = w_ins[14:12];
        // OP-class encoding with funct7[0] set: the M-extension group
        assign w_mdEnc = (w_op[5:2] == 4'b1100) & w_ins[25];
`ifdef DECODE1_MULDIV_EN
        assign w_muldiv = w_mdEnc;
        assign w_mdIll  = 1'b0;
`else
        assign w_muldiv = 1'b0;
        assign w_mdIll  = w_mdEnc;
`endif
        assign w_mem   = ~w_op[6] & (w_op[4:2] == 3'b000) & w_op[0];
        assign w_bj    = (w_op[6:5] == 2'b11);
        assign w_int   = w_op[4] & ~w_mdEnc;
        assign w_wb    = (w_op[2] | w_op[4] | (w_mem & ~w_op[5]))
                       & (w_ins[11:7] != 5'd0) & ~w_mdIll;
        assign w_uns   = (w_int & (w_f3 == 3'b011))
                       | (w_bj & w_f3[1])
                       | (w_muldiv & ((w_f3[1:0] == 2'b11) | ({w_f3[2], w_f3[0]} == 2'b11)));
        assign w_s1    = ~w_uns;
        assign w_s2    = w_muldiv ? ((~w_f3[2] & ~w_f3[1]) | (w_f3[2] & ~w_f3[0])) : w_s1;
        assign w_iimmU = w_int & (w_f3 == 3'b011) & ~w_op[5];
        assign w_iimmS = (w_mem & ~w_op[5]) | (w_op[4:2] == 3'b001)
                       | (w_int & ~w_op[5] & ~w_op[2] & (w_f3[1:0] != 2'b01) & ~w_iimmU);

        // Pack the lane's decode; empty lanes carry all-zero fields and word
        always_comb begin
            w_fld    = '0;
            w_insOut = '0;
            if (in_lane_vld[gi]) begin
                w_fld[c_F_RS1]    = ~(w_op[2] & (w_op[3] | w_op[4]));
                w_fld[c_F_RS2]    = w_op[5] & ~w_op[2];
                w_fld[c_F_WB]     = w_wb;
                w_fld[c_F_INT]    = w_int;
                w_fld[c_F_MULDIV] = w_muldiv;
                w_fld[c_F_MEM]    = w_mem;
                w_fld[c_F_BJ]     = w_bj;
                w_fld[c_F_S1]     = w_s1;
                w_fld[c_F_S2]     = w_s2;
                w_fld[c_F_IIMMU]  = w_iimmU;
                w_fld[c_F_IIMMS]  = w_iimmS;
                w_fld[c_F_UIMM]   = w_op[2];
                w_fld[c_F_UJIMM]  = w_op[3];
                w_fld[c_F_SBIMM]  = ~w_op[2];
                w_fld[c_F_SHAMT]  = ~w_op[5];
                w_fld[c_F_ILL]    = (w_op[1:0] != 2'b11) | w_mdIll;
                w_insOut          = w_ins;
            end
        end

        assign w_decFld[gi]          = w_fld;
        assign w_decIns[32*gi +: 32] = w_insOut;
    end

    // Skid-buffer control and bundle storage; OUT is refilled whenever it is
    // empty or draining, SKD only catches a bundle arriving while OUT stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_EMPTY;
            r_outValid   <= 1'b0;
            r_inReady    <= 1'b1;
            r_outLaneVld <= '0;
            r_outIns     <= '0;
            r_outFld     <= '0;
            r_skdLaneVld <= '0;
            r_skdIns     <= '0;
            r_skdFld     <= '0;
        end else if (flush) begin
            r_state      <= c_ST_EMPTY;
            r_outValid   <= 1'b0;
            r_inReady    <= 1'b1;
            r_outLaneVld <= '0;
            r_outIns     <= '0;
            r_outFld     <= '0;
            r_skdLaneVld <= '0;
            r_skdIns     <= '0;
            r_skdFld     <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_outLaneVld <= in_lane_vld;
                        r_outIns     <= w_decIns;
                        r_outFld     <= w_decFld;
                        r_outValid   <= 1'b1;
                        r_state      <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && w_drain) begin
                        r_outLaneVld <= in_lane_vld;
                        r_outIns     <= w_decIns;
                        r_outFld     <= w_decFld;
                    end else if (w_accept) begin
                        r_skdLaneVld <= in_lane_vld;
                        r_skdIns     <= w_decIns;
                        r_skdFld     <= w_decFld;
                        r_inReady    <= 1'b0;
                        r_state      <= c_ST_TWO;
                    end else if (w_drain) begin
                        r_outLaneVld <= '0;
                        r_outIns     <= '0;
                        r_outFld     <= '0;
                        r_outValid   <= 1'b0;
                        r_state      <= c_ST_EMPTY;
                    end
                end
                c_ST_TWO: begin
                    if (w_drain) begin
                        r_outLaneVld <= r_skdLaneVld;
                        r_outIns     <= r_skdIns;
                        r_outFld     <= r_skdFld;
                        r_skdLaneVld <= '0;
                        r_skdIns     <= '0;
                        r_skdFld     <= '0;
                        r_inReady    <= 1'b1;
                        r_state      <= c_ST_ONE;
                    end
                end
                default: begin
                    r_state    <= c_ST_EMPTY;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                end
            endcase
        end
    end

    // Number of occupied lanes in the bundle currently on the output
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            w_pop = w_pop + CNT_W'(r_outLaneVld[k]);
        end
    end

    // Delivered-lane counter; survives flush, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + w_pop;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_out
        assign out_rs1_en[gi]    = r_outFld[gi][c_F_RS1];
        assign out_rs2_en[gi]    = r_outFld[gi][c_F_RS2];
        assign out_wb_en[gi]     = r_outFld[gi][c_F_WB];
        assign out_int_en[gi]    = r_outFld[gi][c_F_INT];
        assign out_muldiv_en[gi] = r_outFld[gi][c_F_MULDIV];
        assign out_mem_en[gi]    = r_outFld[gi][c_F_MEM];
        assign out_bj_en[gi]     = r_outFld[gi][c_F_BJ];
        assign out_s1_sign[gi]   = r_outFld[gi][c_F_S1];
        assign out_s2_sign[gi]   = r_outFld[gi][c_F_S2];
        assign out_iimm_u_en[gi] = r_outFld[gi][c_F_IIMMU];
        assign out_iimm_s_en[gi] = r_outFld[gi][c_F_IIMMS];
        assign out_uimm_en[gi]   = r_outFld[gi][c_F_UIMM];
        assign out_ujimm_en[gi]  = r_outFld[gi][c_F_UJIMM];
        assign out_sbimm_en[gi]  = r_outFld[gi][c_F_SBIMM];
        assign out_shamt_en[gi]  = r_outFld[gi][c_F_SHAMT];
        assign out_illegal[gi]   = r_outFld[gi][c_F_ILL];
    end

    assign in_ready     = r_inReady;
    assign out_valid    = r_outValid;
    assign out_lane_vld = r_outLaneVld;
    assign out_ins      = r_outIns;
    assign out_mem_any  = |(out_mem_en & r_outLaneVld);
    assign decoded_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode1_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode1_lanes
//  Description : Directed self-checking bench for decode1_lanes (LANES=2,
//                CNT_W=4). Expectations follow DECODE1_MULDIV_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode1_lanes;

    localparam int LANES = 2;
    localparam int CNT_W = 4;

    localparam logic [31:0] c_ADDI = 32'h02A00093;  // addi x1,x0,42
    localparam logic [31:0] c_SW   = 32'h0020A023;  // sw x2,0(x1)
    localparam logic [31:0] c_MUL  = 32'h022081B3;  // mul x3,x1,x2
    localparam logic [31:0] c_A    = 32'h00100093;  // addi x1,x0,1
    localparam logic [31:0] c_B    = 32'h00200093;  // addi x1,x0,2
    localparam logic [31:0] c_C    = 32'h00300093;  // addi x1,x0,3
    localparam logic [31:0] c_D    = 32'h00400093;  // addi x1,x0,4

    logic                clk;
    logic                rst_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [LANES-1:0]    in_lane_vld;
    logic [LANES*32-1:0] in_ins;
    logic                out_valid;
    logic                out_ready;
    logic [LANES-1:0]    out_lane_vld;
    logic [LANES*32-1:0] out_ins;
    logic [LANES-1:0]    out_rs1_en, out_rs2_en, out_wb_en, out_int_en;
    logic [LANES-1:0]    out_muldiv_en, out_mem_en, out_bj_en;
    logic [LANES-1:0]    out_s1_sign, out_s2_sign, out_iimm_u_en, out_iimm_s_en;
    logic [LANES-1:0]    out_uimm_en, out_ujimm_en, out_sbimm_en, out_shamt_en;
    logic [LANES-1:0]    out_illegal;
    logic                out_mem_any;
    logic [CNT_W-1:0]    decoded_cnt;

    int nCmp  = 0;
    int nFail = 0;
    logic [CNT_W-1:0] expCnt;

    decode1_lanes #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_vld(in_lane_vld), .in_ins(in_ins),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_vld(out_lane_vld), .out_ins(out_ins),
        .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
        .out_wb_en(out_wb_en), .out_int_en(out_int_en),
        .out_muldiv_en(out_muldiv_en), .out_mem_en(out_mem_en),
        .out_bj_en(out_bj_en), .out_s1_sign(out_s1_sign),
        .out_s2_sign(out_s2_sign), .out_iimm_u_en(out_iimm_u_en),
        .out_iimm_s_en(out_iimm_s_en), .out_uimm_en(out_uimm_en),
        .out_ujimm_en(out_ujimm_en), .out_sbimm_en(out_sbimm_en),
        .out_shamt_en(out_shamt_en), .out_illegal(out_illegal),
        .out_mem_any(out_mem_any), .decoded_cnt(decoded_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_lane_vld = '0;
        in_ins = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nCmp++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        nCmp++; if (decoded_cnt !== 4'd0) begin nFail++; $display("FAIL reset_cnt: got %0d want 0", decoded_cnt); end
        nCmp++; if (out_mem_any !== 1'b0 || out_lane_vld !== 2'b00) begin nFail++; $display("FAIL reset_fields: got mem_any=%b lane_vld=%b want 0/00", out_mem_any, out_lane_vld); end
        expCnt = 4'd0;
    endtask

    task automatic test_decode();
        in_valid = 1'b1; in_lane_vld = 2'b11; in_ins = {c_SW, c_ADDI}; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        nCmp++; if (out_valid !== 1'b1) begin nFail++; $display("FAIL dec_valid: got %b want 1", out_valid); end
        nCmp++; if ({out_int_en[0], out_wb_en[0], out_iimm_s_en[0], out_rs2_en[0]} !== 4'b1110) begin nFail++; $display("FAIL dec_lane0 int/wb/iimm_s/rs2: got %b want 1110", {out_int_en[0], out_wb_en[0], out_iimm_s_en[0], out_rs2_en[0]}); end
        nCmp++; if ({out_mem_en[1], out_wb_en[1], out_rs2_en[1], out_iimm_s_en[1]} !== 4'b1010) begin nFail++; $display("FAIL dec_lane1 mem/wb/rs2/iimm_s: got %b want 1010", {out_mem_en[1], out_wb_en[1], out_rs2_en[1], out_iimm_s_en[1]}); end
        nCmp++; if (out_mem_any !== 1'b1) begin nFail++; $display("FAIL dec_mem_any: got %b want 1", out_mem_any); end
        nCmp++; if (out_ins !== {c_SW, c_ADDI}) begin nFail++; $display("FAIL dec_ins: got %h want %h", out_ins, {c_SW, c_ADDI}); end
        nCmp++; if ({out_illegal, out_rs1_en, out_sbimm_en, out_shamt_en} !== 8'b00111101) begin nFail++; $display("FAIL dec_misc ill/rs1/sb/shamt: got %b want 00111101", {out_illegal, out_rs1_en, out_sbimm_en, out_shamt_en}); end
        tick();
        expCnt = expCnt + 4'd2;
        nCmp++; if (decoded_cnt !== expCnt) begin nFail++; $display("FAIL dec_cnt: got %0d want %0d", decoded_cnt, expCnt); end
        nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL dec_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_lane_vld = 2'b11;
        in_ins = {c_SW, c_A};
        tick();
        nCmp++; if (in_ready !== 1'b1 || out_ins[31:0] !== c_A) begin nFail++; $display("FAIL bp_first: got rdy=%b ins=%h want 1/%h", in_ready, out_ins[31:0], c_A); end
        in_ins = {c_SW, c_B};
        tick();
        nCmp++; if (in_ready !== 1'b0) begin nFail++; $display("FAIL bp_ready_drop: got %b want 0", in_ready); end
        in_ins = {c_SW, c_C};
        tick();
        nCmp++; if (out_valid !== 1'b1 || out_ins[31:0] !== c_A || in_ready !== 1'b0) begin nFail++; $display("FAIL bp_hold: got v=%b ins=%h rdy=%b want 1/%h/0", out_valid, out_ins[31:0], in_ready, c_A); end
        out_ready = 1'b1;
        tick();
        nCmp++; if (out_valid !== 1'b1 || out_ins[31:0] !== c_B) begin nFail++; $display("FAIL bp_second: got v=%b ins=%h want 1/%h", out_valid, out_ins[31:0], c_B); end
        tick();
        in_valid = 1'b0;
        nCmp++; if (out_valid !== 1'b1 || out_ins[31:0] !== c_C) begin nFail++; $display("FAIL bp_third: got v=%b ins=%h want 1/%h", out_valid, out_ins[31:0], c_C); end
        tick();
        expCnt = expCnt + 4'd6;
        nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
        nCmp++; if (decoded_cnt !== expCnt) begin nFail++; $display("FAIL bp_cnt: got %0d want %0d", decoded_cnt, expCnt); end
    endtask

    task automatic test_muldiv();
        in_valid = 1'b1; in_lane_vld = 2'b01; in_ins = {c_SW, c_MUL}; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef DECODE1_MULDIV_EN
        nCmp++; if ({out_muldiv_en[0], out_int_en[0], out_s1_sign[0], out_s2_sign[0], out_wb_en[0], out_illegal[0]} !== 6'b101110) begin nFail++; $display("FAIL mul_en md/int/s1/s2/wb/ill: got %b want 101110", {out_muldiv_en[0], out_int_en[0], out_s1_sign[0], out_s2_sign[0], out_wb_en[0], out_illegal[0]}); end
`else
        nCmp++; if ({out_muldiv_en[0], out_int_en[0], out_wb_en[0], out_illegal[0]} !== 4'b0001) begin nFail++; $display("FAIL mul_dis md/int/wb/ill: got %b want 0001", {out_muldiv_en[0], out_int_en[0], out_wb_en[0], out_illegal[0]}); end
`endif
        nCmp++; if (out_lane_vld !== 2'b01 || out_ins[63:32] !== 32'h0 || out_rs1_en[1] !== 1'b0) begin nFail++; $display("FAIL mul_empty_lane: got vld=%b ins1=%h rs1=%b want 01/0/0", out_lane_vld, out_ins[63:32], out_rs1_en[1]); end
        tick();
        expCnt = expCnt + 4'd1;
        nCmp++; if (decoded_cnt !== expCnt) begin nFail++; $display("FAIL mul_cnt: got %0d want %0d", decoded_cnt, expCnt); end
    endtask

    task automatic test_empty_bundle();
        in_valid = 1'b1; in_lane_vld = 2'b00; in_ins = {c_SW, c_A}; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        nCmp++; if (out_valid !== 1'b1 || out_lane_vld !== 2'b00 || out_ins !== 64'h0) begin nFail++; $display("FAIL empty_bundle: got v=%b vld=%b ins=%h want 1/00/0", out_valid, out_lane_vld, out_ins); end
        tick();
        nCmp++; if (decoded_cnt !== expCnt || out_valid !== 1'b0) begin nFail++; $display("FAIL empty_cnt: got cnt=%0d v=%b want %0d/0", decoded_cnt, out_valid, expCnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_lane_vld = 2'b11;
        in_ins = {c_SW, c_A}; tick();
        in_ins = {c_SW, c_B}; tick();
        in_ins = {c_SW, c_D}; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        nCmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nFail++; $display("FAIL flush_state: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        out_ready = 1'b1; tick();
        nCmp++; if (out_valid !== 1'b0 || decoded_cnt !== expCnt) begin nFail++; $display("FAIL flush_dropped: got v=%b cnt=%0d want 0/%0d", out_valid, decoded_cnt, expCnt); end
        out_ready = 1'b0; in_valid = 1'b1; in_ins = {c_SW, c_C}; tick();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; tick();
        flush = 1'b0;
        expCnt = expCnt + 4'd2;
        nCmp++; if (out_valid !== 1'b0 || decoded_cnt !== expCnt) begin nFail++; $display("FAIL flush_drain_counts: got v=%b cnt=%0d want 0/%0d", out_valid, decoded_cnt, expCnt); end
    endtask

    task automatic test_wrap_and_reset();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        out_ready = 1'b1; in_valid = 1'b1; in_lane_vld = 2'b11;
        for (int i = 0; i < 9; i++) begin
            in_ins = {c_SW, 32'(i) << 20 | 32'h00000093};
            tick();
            nCmp++; if (out_valid !== 1'b1 || out_ins[31:20] !== 12'(i)) begin nFail++; $display("FAIL wrap_stream[%0d]: got v=%b imm=%0d want 1/%0d", i, out_valid, out_ins[31:20], i); end
        end
        in_valid = 1'b0;
        tick();
        nCmp++; if (decoded_cnt !== 4'd2) begin nFail++; $display("FAIL wrap_cnt: got %0d want 2", decoded_cnt); end
        in_valid = 1'b1; out_ready = 1'b0; tick();
        in_valid = 1'b0;
        rst_n = 1'b0; #1;
        nCmp++; if (out_valid !== 1'b0 || decoded_cnt !== 4'd0 || in_ready !== 1'b1) begin nFail++; $display("FAIL async_reset: got v=%b cnt=%0d rdy=%b want 0/0/1", out_valid, decoded_cnt, in_ready); end
        tick(); rst_n = 1'b1; out_ready = 1'b1; tick();
        nCmp++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL post_reset_no_delivery: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_muldiv();
        test_empty_bundle();
        test_flush();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
